// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: upstream stage for the UART transmitter.
//   Holds host bytes in a DEPTH-entry FIFO. It passes them to the transmitter one
//   at a time through a trmt/tx_data/tx_done handshake. It also generates the
//   baud_tick bit-period enable. The baud divider is re-phased at every frame start.
//
// Ports:
//   clk, rst_n       system clock; asynchronous active-low reset
//   wr_en, wr_data   host push strobe and byte (dropped when full)
//   full, empty      registered FIFO status
//   count            registered FIFO occupancy
//   ovf, ovf_clr     sticky overflow flag and its clear
//   tx_done          from transmitter: 1 = idle / frame finished
//   trmt, tx_data    registered one-cycle start pulse and byte to transmitter
//   baud_tick        one-cycle bit-period enable
//
// Build option: define UART_FEEDER_OVF_EN to implement the sticky overflow
// register. When it is undefined, ovf is tied low and ovf_clr is ignored.
module uart_tx_feeder #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  input  logic                     ovf_clr,
  input  logic                     tx_done,
  output logic                     trmt,
  output logic [7:0]               tx_data,
  output logic                     baud_tick
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_MAX = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            trmt_q, trmt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [BW-1:0]   baud_cnt_q, baud_cnt_d;
  logic            push, pop;

  // A push is judged on the registered full flag, so a byte that arrives
  // while full is dropped even if a pop frees a slot on the same edge.
  assign push = wr_en && !full_q;

  // ---------------- FIFO ----------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // ---------------- Feed FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!empty_q && tx_done) state_d = WAIT_BUSY;
      WAIT_BUSY: if (!tx_done)            state_d = WAIT_DONE;
      WAIT_DONE: if (tx_done)             state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // A pop can only start from IDLE, and IDLE always moves on to WAIT_BUSY.
  // Therefore trmt can never be high on two consecutive cycles.
  always_comb begin
    pop       = 1'b0;
    trmt_d    = 1'b0;
    tx_data_d = tx_data_q;
    if (state_q == IDLE && !empty_q && tx_done) begin
      pop       = 1'b1;
      trmt_d    = 1'b1;
      tx_data_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trmt_q    <= 1'b0;
      tx_data_q <= '0;
    end else begin
      trmt_q    <= trmt_d;
      tx_data_q <= tx_data_d;
    end
  end

  // ---------------- Baud divider ----------------
  // The counter restarts when trmt is high, so the start bit gets a full period.
  always_comb begin
    if (trmt_q || baud_cnt_q == BAUD_MAX) baud_cnt_d = '0;
    else                                  baud_cnt_d = baud_cnt_q + BW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) baud_cnt_q <= '0;
    else        baud_cnt_q <= baud_cnt_d;
  end

  // ---------------- Overflow flag ----------------
`ifdef UART_FEEDER_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && full_q) ovf_d = 1'b1;
    else if (ovf_clr)    ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf = 1'b0;
`endif

  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign trmt      = trmt_q;
  assign tx_data   = tx_data_q;
  assign baud_tick = (baud_cnt_q == BAUD_MAX);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Testbench for uart_tx_feeder (DEPTH=8, BAUD_DIV=4).
// The bench runs directed vector tables and hand-written corner sequences.
// It then runs a randomized run against a queue-based reference model.
module tb_uart_tx_feeder;

  localparam int DEPTH    = 8;
  localparam int BAUD_DIV = 4;
`ifdef UART_FEEDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       tx_done = 1'b1;
  logic       full, empty, ovf, trmt, baud_tick;
  logic [3:0] count;
  logic [7:0] tx_data;

  int checks = 0;
  int errors = 0;

  uart_tx_feeder #(.DEPTH(DEPTH), .BAUD_DIV(BAUD_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .ovf(ovf), .ovf_clr(ovf_clr),
    .tx_done(tx_done), .trmt(trmt), .tx_data(tx_data), .baud_tick(baud_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic td);
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    ovf_clr = 1'b0;
    tx_done = td;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- Directed vector table ----------------
  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       td;
    logic       clr;
    logic [3:0] cnt;
    logic       fl;
    logic       em;
    logic       ov;
    logic       tr;
    logic [7:0] txd;
  } vec_t;

  vec_t tbl[20];

  // ---------------- Reference model ----------------
  // A byte queue, plus a flag saying the feeder may start a new byte.
  // The feeder becomes free again after tx_done has been seen low and then high.
  logic [7:0] mq[$];
  bit         m_free, m_seen_low, m_trmt, m_ovf;
  logic [7:0] m_data;
  int         m_phase;     // cycles since reset release or since the last trmt cycle
  int         tx_left;

  task automatic model_reset();
    mq.delete();
    m_free = 1'b1; m_seen_low = 1'b0; m_trmt = 1'b0; m_ovf = 1'b0;
    m_data = 8'h00; m_phase = 0;
  endtask

  task automatic model_step();
    int sz;
    bit take;
    sz   = mq.size();
    take = m_free && (sz > 0) && tx_done;
    if (OVF_ON) begin
      if (wr_en && sz == DEPTH) m_ovf = 1'b1;
      else if (ovf_clr)         m_ovf = 1'b0;
    end
    m_phase = m_trmt ? 0 : m_phase + 1;
    if (take) begin
      m_data     = mq.pop_front();
      m_trmt     = 1'b1;
      m_free     = 1'b0;
      m_seen_low = 1'b0;
    end else begin
      m_trmt = 1'b0;
      if (!m_free) begin
        if (!m_seen_low) begin
          if (!tx_done) m_seen_low = 1'b1;
        end else if (tx_done) begin
          m_free = 1'b1;
        end
      end
    end
    if (wr_en && sz < DEPTH) mq.push_back(wr_data);
  endtask

  initial begin
    int got, highs, rate;
    bit seen;

    // ---- reset state ----
    do_reset(1'b0);
    chk("reset.full",      32'(full),      32'd0);
    chk("reset.empty",     32'(empty),     32'd1);
    chk("reset.count",     32'(count),     32'd0);
    chk("reset.ovf",       32'(ovf),       32'd0);
    chk("reset.trmt",      32'(trmt),      32'd0);
    chk("reset.tx_data",   32'(tx_data),   32'h00);
    chk("reset.baud_tick", 32'(baud_tick), 32'd0);

    // ---- table: fill to full, overflow, pop with tx_done held, hold in WAIT_BUSY ----
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 8'(i + 1), 1'b0, 1'b0, 4'(i + 1), (i == 7), 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[8]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0, OVF_ON, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, OVF_ON, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0,   1'b0, 8'h00};
    tbl[11] = '{1'b1, 8'hEE, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0, OVF_ON, 1'b1, 8'h01};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0,   1'b0, 8'h01};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0,   1'b0, 8'h01};
    tbl[14] = '{1'b1, 8'h09, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0,   1'b0, 8'h01};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0,   1'b0, 8'h01};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0,   1'b0, 8'h01};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0,   1'b0, 8'h01};
    tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0,   1'b1, 8'h02};
    tbl[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0,   1'b0, 8'h02};

    for (int i = 0; i < 20; i++) begin
      wr_en = tbl[i].we; wr_data = tbl[i].wd; tx_done = tbl[i].td; ovf_clr = tbl[i].clr;
      @(negedge clk);
      chk($sformatf("vec%0d.count", i),   32'(count),   32'(tbl[i].cnt));
      chk($sformatf("vec%0d.full", i),    32'(full),    32'(tbl[i].fl));
      chk($sformatf("vec%0d.empty", i),   32'(empty),   32'(tbl[i].em));
      chk($sformatf("vec%0d.ovf", i),     32'(ovf),     32'(tbl[i].ov));
      chk($sformatf("vec%0d.trmt", i),    32'(trmt),    32'(tbl[i].tr));
      chk($sformatf("vec%0d.tx_data", i), 32'(tx_data), 32'(tbl[i].txd));
    end
    wr_en = 1'b0; ovf_clr = 1'b0;

    // ---- single byte latency, baud re-phase, handshake hold ----
    do_reset(1'b1);
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    chk("single.empty_after_N", 32'(empty), 32'd0);
    chk("single.trmt_after_N",  32'(trmt),  32'd0);
    @(negedge clk);
    chk("single.trmt",    32'(trmt),    32'd1);
    chk("single.tx_data", 32'(tx_data), 32'hA5);
    chk("single.empty",   32'(empty),   32'd1);
    highs = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (trmt) highs++;
      if (k <= 4) chk($sformatf("single.baud_tick+%0d", k), 32'(baud_tick), 32'(k == 4));
    end
    chk("hold.no_second_trmt", 32'(highs), 32'd0);

    // ---- simultaneous push/pop at count 3, order preserved ----
    do_reset(1'b0);
    for (int j = 0; j < 3; j++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + j);
      @(negedge clk);
    end
    chk("pushpop.count_before", 32'(count), 32'd3);
    wr_en = 1'b1; wr_data = 8'h13; tx_done = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    chk("pushpop.trmt",    32'(trmt),    32'd1);
    chk("pushpop.tx_data", 32'(tx_data), 32'h10);
    chk("pushpop.count",   32'(count),   32'd3);
    tx_done = 1'b0;
    got = 0;
    for (int c = 0; c < 60 && got < 3; c++) begin
      @(negedge clk);
      if (trmt) begin
        chk($sformatf("pushpop.order%0d", got), 32'(tx_data), 32'(8'h11 + got));
        got++;
        tx_done = 1'b0;
      end else begin
        tx_done = 1'b1;
      end
    end
    chk("pushpop.bytes_seen", 32'(got), 32'd3);
    @(negedge clk);
    chk("pushpop.empty_end", 32'(empty), 32'd1);

    // ---- reset mid-frame ----
    do_reset(1'b1);
    for (int j = 0; j < 5; j++) begin
      wr_en = 1'b1; wr_data = 8'(8'h20 + j);
      @(negedge clk);
      if (trmt) tx_done = 1'b0;
    end
    wr_en = 1'b0;
    chk("midrst.count_before",   32'(count),   32'd4);
    chk("midrst.tx_data_before", 32'(tx_data), 32'h20);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.full",      32'(full),      32'd0);
    chk("midrst.empty",     32'(empty),     32'd1);
    chk("midrst.count",     32'(count),     32'd0);
    chk("midrst.ovf",       32'(ovf),       32'd0);
    chk("midrst.trmt",      32'(trmt),      32'd0);
    chk("midrst.tx_data",   32'(tx_data),   32'h00);
    chk("midrst.baud_tick", 32'(baud_tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; tx_done = 1'b1;
    highs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (trmt) highs++;
    end
    chk("midrst.no_trmt_after", 32'(highs), 32'd0);
    wr_en = 1'b1; wr_data = 8'h33;
    @(negedge clk);
    wr_en = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      if (trmt) begin
        seen = 1'b1;
        chk("midrst.refill_data", 32'(tx_data), 32'h33);
      end
    end
    chk("midrst.refill_trmt", 32'(seen), 32'd1);

    // ---- randomized run against reference model ----
    do_reset(1'b1);
    model_reset();
    tx_left = 0;
    rate = 40;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd.count",     32'(count),     32'(mq.size()));
      chk("rnd.full",      32'(full),      32'(mq.size() == DEPTH));
      chk("rnd.empty",     32'(empty),     32'(mq.size() == 0));
      chk("rnd.ovf",       32'(ovf),       32'(m_ovf));
      chk("rnd.trmt",      32'(trmt),      32'(m_trmt));
      chk("rnd.tx_data",   32'(tx_data),   32'(m_data));
      chk("rnd.baud_tick", 32'(baud_tick), 32'((m_phase % BAUD_DIV) == BAUD_DIV - 1));
      // transmitter: goes busy after trmt, finishes after a few bit periods
      if (trmt) begin
        tx_done = 1'b0;
        tx_left = $urandom_range(1, 3);
      end else if (!tx_done && baud_tick) begin
        tx_left--;
        if (tx_left <= 0) tx_done = 1'b1;
      end
      if (cyc % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       rate = 10;
          1:       rate = 40;
          default: rate = 90;
        endcase
      end
      wr_en   = ($urandom_range(0, 99) < rate);
      wr_data = 8'($urandom());
      ovf_clr = ($urandom_range(0, 19) == 0);
      model_step();
      @(negedge clk);
    end
    wr_en = 1'b0; ovf_clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Upstream stage for the UART transmitter. Buffers host bytes in a small FIFO, hands them one at a time to the transmitter via a trmt/tx_data/tx_done handshake, and generates the baud_tick bit-period enable the transmitter shifts on. The baud divider is re-phased at every frame start so the start bit gets a full bit period.

Parameters:
DEPTH, 8, FIFO entries; power of 2, at least 2
BAUD_DIV, 434, clk cycles per bit (50 MHz / 115200); at least 2

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
wr_en  in  1  host write strobe; pushes wr_data when not full
wr_data  in  8  byte to transmit
full  out  1  FIFO holds DEPTH entries
empty  out  1  FIFO holds 0 entries
count  out  $clog2(DEPTH)+1  current occupancy
ovf  out  1  sticky overflow flag; see Optional Feature
ovf_clr  in  1  clears ovf; see Optional Feature
tx_done  in  1  from transmitter; 1 = idle or frame finished, falls the cycle after trmt
trmt  out  1  one-cycle start pulse to transmitter; registered
tx_data  out  8  byte for transmitter; registered, stable while trmt=1
baud_tick  out  1  one-cycle bit-period enable to transmitter

Behaviour:
- Reset values: full=0, empty=1, count=0, ovf=0, trmt=0, tx_data=8'h00, baud_tick=0. Pointers, divider counter and FSM are reset to IDLE.
- FIFO: circular buffer with wr_ptr/rd_ptr, log2(DEPTH) bits each, wrapping naturally. count is a separate register. full, empty and count are registered and reflect state after the edge.
- Push: wr_en && !full writes mem[wr_ptr] and increments wr_ptr.
- Push while full: the byte is dropped and pointers are unchanged, even if a pop occurs in the same cycle.
- Push and pop in the same cycle (not full): count is unchanged and both pointers advance.
- Feed FSM states are IDLE, WAIT_BUSY and WAIT_DONE.
- IDLE: if !empty && tx_done, pop mem[rd_ptr] into tx_data, set trmt<=1 and go to WAIT_BUSY. Otherwise stay in IDLE with trmt=0.
- WAIT_BUSY: trmt<=0. Go to WAIT_DONE when tx_done==0; otherwise stay.
- WAIT_DONE: go to IDLE when tx_done==1.
- No pop occurs in WAIT_BUSY or WAIT_DONE. trmt is never high for two consecutive cycles.
- Latency: wr_en at edge N into an empty FIFO with the FSM idle and tx_done=1 gives empty=0 after N, and trmt=1 with valid tx_data for the cycle after edge N+1.
- Back-to-back bytes: the next trmt is issued in the cycle after tx_done returns high. There are no extra idle cycles beyond the FSM return to IDLE.
- Baud divider: counter counts 0 to BAUD_DIV-1 and wraps. baud_tick = (cnt == BAUD_DIV-1), combinational from the counter.
- While trmt=1, the counter is forced to 0 on the next edge. The first tick therefore arrives BAUD_DIV cycles after the trmt cycle, and a full frame spans 10 ticks.
- Reset asserted mid-frame: all state returns to reset values, queued bytes are discarded, and no trmt is issued until the FIFO is refilled.

Optional Feature:
UART_FEEDER_OVF_EN
- Defined: ovf is set on any wr_en while full=1 and held until ovf_clr=1. If set and clear occur in the same cycle, set wins.
- Not defined: ovf is tied to 0, ovf_clr is ignored, and no overflow register is synthesized. Drop-on-full behaviour is unchanged.

Test Plan:
- Use a transmitter model, DEPTH=8, BAUD_DIV=4.
- Single byte: write 8'hA5 into an idle FIFO with tx_done=1 -> trmt pulses 1 cycle, 2 cycles after wr_en, with tx_data=8'hA5. empty returns to 1. The next baud_tick comes 4 cycles after trmt.
- Burst: write 8'h01..8'h08 on consecutive cycles -> full=1 and count=8 after the 8th write; this assumes no pop has occurred yet. Bytes then reach the transmitter in order, exactly one trmt per tx_done rising edge, and after the last frame empty=1 and count=0.
- Overflow: with the FIFO full, write 8'hFF -> byte dropped, count stays 8. With UART_FEEDER_OVF_EN, ovf=1 until an ovf_clr pulse, then 0. Without the macro, ovf stays 0.
- Simultaneous push/pop: push on the same cycle the FSM pops, at count=3 -> count stays 3, and the data order is preserved.
- Handshake hold: keep tx_done=1 after trmt (a transmitter that never goes busy) -> FSM stays in WAIT_BUSY and no second trmt is issued.
- Reset mid-frame: assert rst_n=0 with 4 bytes queued and a frame in progress -> all outputs go to reset values immediately. After release, no trmt is issued until a new write.
